mux_nx1_bus: RTL and testbench

Parametrised, registered N-to-1 bus multiplexer with break-before-make channel switching. It selects one of CHANNELS input words and drives the registered result onto a shared tristate bus. On every channel change it enforces a programmable dead time (TURNOFF cycles) with the driver disabled. A valid/ready handshake lets a controller request channel changes safely.

---
 rtl/mux_nx1_bus.sv | 158 +++++++++++++++
 tb/tb_mux_nx1_bus.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_bus.sv
// Registered N-to-1 bus multiplexer with break-before-make switching.
// Ports: clk, rst_n (async, active-low), in_data (packed channel words),
//   sel/sel_valid/sel_ready (channel request handshake), out/out_en
//   (registered word and tristate driver enable), cur_sel (owned or pending
//   channel), busy (dead-time gap active), sel_err (out-of-range pulse).
module mux_nx1_bus #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int TURNOFF  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_valid,
    output logic                      sel_ready,
    output logic [WIDTH-1:0]          out,
    output logic                      out_en,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      busy,
    output logic                      sel_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);
    localparam logic [3:0]     TOFF   = 4'(TURNOFF);
    localparam bit             NO_GAP = (TURNOFF == 0);

    state_t            state;
    state_t            nxt_state;
    logic [SEL_W-1:0]  cur_q;
    logic [SEL_W-1:0]  nxt_sel;
    logic [3:0]        cnt;
    logic [3:0]        nxt_cnt;
    logic              pend;
    logic              nxt_pend;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  nxt_out;
    logic              err_q;
    logic              nxt_err;
    logic              accept;
    logic              sel_ok;

    // Compare-based select: an out-of-range code matches no channel and
    // yields zero, so it can never index past the packed input.
    function automatic logic [WIDTH-1:0] pick(
        input logic [CHANNELS*WIDTH-1:0] d,
        input logic [SEL_W-1:0]          s
    );
        pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (s == SEL_W'(k)) pick = d[k*WIDTH +: WIDTH];
        end
    endfunction

    // With a power-of-two channel count every code is legal.
    generate
        if ((2 ** SEL_W) == CHANNELS) begin : g_full
            assign sel_ok = 1'b1;
        end else begin : g_part
            assign sel_ok = ({1'b0, sel} < CH_LIM);
        end
    endgenerate

    assign accept = sel_valid && sel_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur_q <= '0;
            cnt   <= '0;
            pend  <= 1'b0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= nxt_state;
            cur_q <= nxt_sel;
            cnt   <= nxt_cnt;
            pend  <= nxt_pend;
            out_q <= nxt_out;
            err_q <= nxt_err;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_sel   = cur_q;
        nxt_cnt   = cnt;
        nxt_pend  = pend;
        nxt_out   = '0;
        nxt_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!sel_ok) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_state = DRIVE;
                        nxt_sel   = sel;
                        nxt_out   = pick(in_data, sel);
                    end
                end
            end
            DRIVE: begin
                nxt_out = pick(in_data, cur_q);
                if (accept && !sel_ok) begin
                    // Bad request drops the bus; nothing is re-driven.
                    nxt_err  = 1'b1;
                    nxt_pend = 1'b0;
                    nxt_out  = '0;
                    if (NO_GAP) begin
                        nxt_state = IDLE;
                    end else begin
                        nxt_state = GAP;
                        nxt_cnt   = TOFF;
                    end
                end else if (accept && sel != cur_q) begin
                    nxt_sel = sel;
                    if (NO_GAP) begin
                        nxt_out = pick(in_data, sel);
                    end else begin
                        nxt_state = GAP;
                        nxt_cnt   = TOFF;
                        nxt_pend  = 1'b1;
                        nxt_out   = '0;
                    end
                end
            end
            GAP: begin
                nxt_cnt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    nxt_cnt   = '0;
                    nxt_state = pend ? DRIVE : IDLE;
                    if (pend) nxt_out = pick(in_data, cur_q);
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_comb begin
        out_en    = (state == DRIVE);
        busy      = (state == GAP);
        sel_ready = (state != GAP);
        out       = out_q;
        cur_sel   = cur_q;
        sel_err   = err_q;
    end

endmodule

// File: tb/tb_mux_nx1_bus.sv
// Randomised self-checking bench for mux_nx1_bus.
// Three instances: (4 ch, gap 2), (3 ch, gap 3), (4 ch, no gap).
module tb_mux_nx1_bus;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] w [3][4];
    logic       v [3];
    logic [1:0] s [3];

    logic [31:0] in_a;
    logic [23:0] in_b;
    logic [31:0] in_c;
    assign in_a = {w[0][3], w[0][2], w[0][1], w[0][0]};
    assign in_b = {w[1][2], w[1][1], w[1][0]};
    assign in_c = {w[2][3], w[2][2], w[2][1], w[2][0]};

    logic       rdy_a, en_a, busy_a, err_a;
    logic       rdy_b, en_b, busy_b, err_b;
    logic       rdy_c, en_c, busy_c, err_c;
    logic [7:0] out_a, out_b, out_c;
    logic [1:0] cur_a, cur_b, cur_c;

    mux_nx1_bus #(.WIDTH(8), .CHANNELS(4), .TURNOFF(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_a), .sel(s[0]),
        .sel_valid(v[0]), .sel_ready(rdy_a), .out(out_a), .out_en(en_a),
        .cur_sel(cur_a), .busy(busy_a), .sel_err(err_a)
    );
    mux_nx1_bus #(.WIDTH(8), .CHANNELS(3), .TURNOFF(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_b), .sel(s[1]),
        .sel_valid(v[1]), .sel_ready(rdy_b), .out(out_b), .out_en(en_b),
        .cur_sel(cur_b), .busy(busy_b), .sel_err(err_b)
    );
    mux_nx1_bus #(.WIDTH(8), .CHANNELS(4), .TURNOFF(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_c), .sel(s[2]),
        .sel_valid(v[2]), .sel_ready(rdy_c), .out(out_c), .out_en(en_c),
        .cur_sel(cur_c), .busy(busy_c), .sel_err(err_c)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: drv = channel on the bus (-1 none), dead = dead cycles
    // still to go, tgt = channel to take over after the dead time.
    int m_drv [3];
    int m_dead[3];
    int m_tgt [3];
    int m_cur [3];
    int m_out [3];
    int m_err [3];

    function automatic int nch(input int i);
        return (i == 1) ? 3 : 4;
    endfunction

    function automatic int toff(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_drv[i]  = -1;
            m_dead[i] = 0;
            m_tgt[i]  = -1;
            m_cur[i]  = 0;
            m_out[i]  = 0;
            m_err[i]  = 0;
        end
    endtask

    task automatic model_step(input int i);
        int n, t, sl;
        n = nch(i);
        t = toff(i);
        sl = int'(s[i]);
        m_err[i] = 0;
        if (m_dead[i] > 0) begin
            m_dead[i]--;
            if (m_dead[i] == 0 && m_tgt[i] >= 0) m_drv[i] = m_tgt[i];
        end else if (v[i]) begin
            if (sl >= n) begin
                m_err[i] = 1;
                if (m_drv[i] >= 0) begin
                    m_drv[i] = -1;
                    m_tgt[i] = -1;
                    m_dead[i] = t;
                end
            end else if (m_drv[i] < 0) begin
                m_drv[i] = sl;
                m_cur[i] = sl;
            end else if (sl != m_drv[i]) begin
                m_cur[i] = sl;
                if (t > 0) begin
                    m_drv[i] = -1;
                    m_dead[i] = t;
                    m_tgt[i] = sl;
                end else begin
                    m_drv[i] = sl;
                end
            end
        end
        m_out[i] = (m_drv[i] >= 0 && m_dead[i] == 0) ? int'(w[i][m_drv[i]]) : 0;
    endtask

    task automatic obs(input int i, output logic [7:0] o, output logic e,
                       output logic b, output logic r, output logic er,
                       output logic [1:0] c);
        case (i)
            0: begin o = out_a; e = en_a; b = busy_a; r = rdy_a; er = err_a; c = cur_a; end
            1: begin o = out_b; e = en_b; b = busy_b; r = rdy_b; er = err_b; c = cur_b; end
            default: begin o = out_c; e = en_c; b = busy_c; r = rdy_c; er = err_c; c = cur_c; end
        endcase
    endtask

    task automatic check_all();
        logic [7:0] o;
        logic e, b, r, er;
        logic [1:0] c;
        bit en_x, busy_x;
        for (int i = 0; i < 3; i++) begin
            obs(i, o, e, b, r, er, c);
            en_x   = (m_drv[i] >= 0 && m_dead[i] == 0);
            busy_x = (m_dead[i] > 0);
            chk($sformatf("u%0d out", i), 32'(o), 32'(m_out[i]));
            chk($sformatf("u%0d out_en", i), 32'(e), 32'(en_x));
            chk($sformatf("u%0d busy", i), 32'(b), 32'(busy_x));
            chk($sformatf("u%0d sel_ready", i), 32'(r), 32'(!busy_x));
            chk($sformatf("u%0d sel_err", i), 32'(er), 32'(m_err[i]));
            chk($sformatf("u%0d cur_sel", i), 32'(c), 32'(m_cur[i]));
        end
    endtask

    task automatic tick();
        if (rst_n) begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic req(input int i, input int sl);
        v[i] = 1'b1;
        s[i] = 2'(sl);
        tick();
        v[i] = 1'b0;
    endtask

    // Called just after a negedge: reset asserts mid-cycle and is checked
    // before any clock edge, then released on the following negedge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0;
            s[i] = 2'd0;
            for (int k = 0; k < 4; k++) w[i][k] = 8'(k * 16 + i);
        end
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        w[0][2] = 8'hA5;
        req(0, 2);
        chk("tp1 out", 32'(out_a), 32'hA5);
        chk("tp1 en", 32'(en_a), 32'd1);

        w[0][1] = 8'h3C;
        req(0, 1);
        chk("tp2 gap1 en", 32'(en_a), 32'd0);
        tick();
        chk("tp2 gap2 busy", 32'(busy_a), 32'd1);
        tick();
        chk("tp2 out", 32'(out_a), 32'h3C);

        for (int j = 0; j < 3; j++) begin
            w[0][1] = 8'(8'h50 + j);
            req(0, 1);
            chk("tp3 follow", 32'(out_a), 32'(8'h50 + j));
        end

        req(1, 1);
        req(1, 3);
        chk("tp4 err", 32'(err_b), 32'd1);
        tick();
        chk("tp4 err once", 32'(err_b), 32'd0);
        tick();
        tick();
        chk("tp4 idle en", 32'(en_b), 32'd0);
        chk("tp4 cur", 32'(cur_b), 32'd1);

        w[2][0] = 8'h11;
        w[2][3] = 8'h99;
        req(2, 0);
        req(2, 3);
        chk("tp5 out", 32'(out_c), 32'h99);
        chk("tp5 en", 32'(en_c), 32'd1);

        req(0, 3);
        tick();
        async_reset();
        chk("tp6 en", 32'(en_a), 32'd0);
        w[0][0] = 8'h77;
        req(0, 0);
        chk("tp6 out", 32'(out_a), 32'h77);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = ($urandom_range(0, 3) == 0);
                s[i] = 2'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++) w[i][k] = 8'($urandom);
            end
            tick();
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
